// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide (shift-add / restoring division, 34-edge latency).
// Optional MULDIV_FAST_MUL_EN: single-edge combinational multiply; division unchanged.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      MDOp,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] MDRes
);
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, nxt;
  logic [4:0]  cnt;
  logic [63:0] p;
  logic [31:0] d;
  logic [2:0]  op;
  logic        neg;
  logic        sa, sb, div0, ovf, special, fast, neg_in;
  logic [31:0] a_abs, b_abs, spec_res, fast_res, fix_res;
  logic [63:0] fp, pn;
  logic [32:0] madd, dsub;
  always_comb begin
    sa       = A[31] & (MDOp[2] ? ~MDOp[0] : (MDOp[0] ^ MDOp[1]));
    sb       = B[31] & ((MDOp == 3'b001) | (MDOp[2] & ~MDOp[0]));
    a_abs    = sa ? -A : A;
    b_abs    = sb ? -B : B;
    div0     = MDOp[2] & (B == 32'd0);
    ovf      = MDOp[2] & ~MDOp[0] & (A == 32'h8000_0000) & (B == 32'hFFFF_FFFF);
    special  = div0 | ovf;
    spec_res = div0 ? (MDOp[1] ? A : 32'hFFFF_FFFF) : (MDOp[1] ? 32'd0 : 32'h8000_0000);
    neg_in   = (MDOp[2] & MDOp[1]) ? sa : sa ^ sb;
    fast     = FAST & ~MDOp[2];
    // sign-extended 64x64 product keeps the correct low 64 bits of the two's complement result
    fp       = {{32{sa}}, A} * {{32{sb}}, B};
    fast_res = (MDOp == 3'b000) ? fp[31:0] : fp[63:32];
    madd     = {1'b0, p[63:32]} + (p[0] ? {1'b0, d} : 33'd0);
    dsub     = p[63:31] - {1'b0, d};
    pn       = neg ? -p : p;
    fix_res  = op[2] ? (op[1] ? (neg ? -p[63:32] : p[63:32]) : (neg ? -p[31:0] : p[31:0]))
                     : ((op[1:0] == 2'b00) ? pn[31:0] : pn[63:32]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? ((special | fast) ? DONE : CALC) : IDLE;
      CALC: nxt = (cnt == 5'd31) ? FIX : CALC;
      FIX:  nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = (state == CALC) | (state == FIX);
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt   <= '0;
      p     <= '0;
      d     <= '0;
      op    <= '0;
      neg   <= 1'b0;
      MDRes <= '0;
    end else if (state == IDLE && start) begin
      cnt <= '0;
      op  <= MDOp;
      neg <= neg_in;
      d   <= MDOp[2] ? b_abs : a_abs;
      p   <= {32'd0, MDOp[2] ? a_abs : b_abs};
      if (special) MDRes <= spec_res;
      else if (fast) MDRes <= fast_res;
    end else if (state == CALC) begin
      cnt <= cnt + 5'd1;
      p   <= op[2] ? (dsub[32] ? {p[62:0], 1'b0} : {dsub[31:0], p[30:0], 1'b1})
                   : {madd, p[31:1]};
    end else if (state == FIX) MDRes <= fix_res;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed + randomized checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0]  MDOp = '0;
  logic [31:0] A = '0, B = '0;
  logic        busy, done;
  logic [31:0] MDRes;
  int vec = 0, errs = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .MDOp(MDOp), .A(A), .B(B),
    .busy(busy), .done(done), .MDRes(MDRes)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = $signed(a), sb = $signed(b);
    longint ua = {32'd0, a}, ub = {32'd0, b};
    longint r;
    longint unsigned ru;
    case (op)
      3'b000: begin ru = ua * ub; return ru[31:0]; end
      3'b001: begin r = sa * sb; return r[63:32]; end
      3'b010: begin r = sa * ub; return r[63:32]; end
      3'b011: begin ru = ua * ub; return ru[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = sa / sb; return r[31:0];
      end
      3'b101: begin if (b == 0) return 32'hFFFF_FFFF; r = ua / ub; return r[31:0]; end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r = sa % sb; return r[31:0];
      end
      default: begin if (b == 0) return a; r = ua % ub; return r[31:0]; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (is_special(op, a, b) || (FAST && !op[2])) ? 1 : 34;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one operation, optionally pokes a second start mid-flight, checks latency/result/busy/done width.
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inj);
    int n, lat;
    bit bs;
    int el;
    el = exp_lat(op, a, b);
    @(negedge clk);
    start = 1'b1; MDOp = op; A = a; B = b;
    @(posedge clk);
    #1 start = 1'b0;
    A = ~a; B = b ^ 32'h5A5A_0001;
    n = 1; lat = 0; bs = 1'b0;
    while (lat == 0 && n <= 60) begin
      @(negedge clk);
      bs |= busy;
      if (done) lat = n;
      else begin
        if (inj && n == 5) begin start = 1'b1; MDOp = op ^ 3'b001; A = a + 32'd13; B = b + 32'd1; end
        if (inj && n == 6) start = 1'b0;
        @(posedge clk);
        n++;
      end
    end
    chk($sformatf("latency op=%0d", op), lat, el);
    chk($sformatf("result op=%0d a=%h b=%h", op, a, b), MDRes, model(op, a, b));
    chk($sformatf("busy_seen op=%0d", op), {31'd0, bs}, {31'd0, el != 1});
    @(negedge clk);
    chk("done_width", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int e, prev, pulses;
    logic [2:0] rop;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    chk("reset_mdres", MDRes, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    // reset in the middle of a division
    @(negedge clk);
    start = 1'b1; MDOp = 3'b100; A = 32'd100; B = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_mdres", MDRes, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    @(negedge clk) rst = 1'b0;
    run(3'b100, 32'd100, 32'd7, 1'b0);
    chk("div_100_7", MDRes, 32'd14);
    run(3'b100, 32'hFFFF_FF9C, 32'd7, 1'b0);
    chk("div_m100_7", MDRes, 32'hFFFF_FFF2);
    run(3'b110, 32'hFFFF_FF9C, 32'd7, 1'b0);
    chk("rem_m100_7", MDRes, 32'hFFFF_FFFE);
    run(3'b111, 32'd100, 32'd7, 1'b0);
    chk("remu_100_7", MDRes, 32'd2);
    repeat (10) @(negedge clk);
    chk("hold_10_cycles", MDRes, 32'd2);
    run(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("mul_ff", MDRes, 32'h0000_0001);
    run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("mulh_ff", MDRes, 32'h0000_0000);
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("mulhu_ff", MDRes, 32'hFFFF_FFFE);
    run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("mulhsu_ff", MDRes, 32'hFFFF_FFFF);
    run(3'b100, 32'd5, 32'd0, 1'b0);
    chk("div_by_zero", MDRes, 32'hFFFF_FFFF);
    run(3'b111, 32'd5, 32'd0, 1'b0);
    chk("remu_by_zero", MDRes, 32'd5);
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_overflow", MDRes, 32'h8000_0000);
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("rem_overflow", MDRes, 32'd0);
    run(3'b100, 32'd1000, 32'd3, 1'b1);
    run(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1; MDOp = 3'b000; A = 32'd6; B = 32'd7;
    e = 0; prev = 0; pulses = 0;
    while (pulses < 3 && e < 200) begin
      @(posedge clk); e++;
      @(negedge clk);
      if (done) begin
        chk("b2b_result", MDRes, 32'd42);
        if (prev > 0) chk("b2b_spacing", e - prev, FAST ? 32'd2 : 32'd35);
        prev = e; pulses++;
      end
    end
    chk("b2b_pulses", pulses, 32'd3);
    start = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: ra = {16'd0, ra[15:0]};
        default: ;
      endcase
      run(rop, ra, rb, i % 5 == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
